voice_alloc: RTL
================

# voice_alloc

Polyphonic voice allocator between the PS/2 keyboard decoder and the wavetable voice oscillators. Watches the 20-bit held-key bitmask, detects key presses and releases, and assigns each pressed key to one of NUM_VOICES oscillator voices. A free voice is used when one exists; otherwise the least-recently-allocated voice is stolen. Emits per-voice gate, key index and a one-cycle note-on trigger.

## Interface
- NUM_VOICES, 4: number of oscillator voices, 2..8.
- KEY_W, 20: width of key bitmask.
- VALID_MASK, 20'h07FFF: keys eligible for allocation. Bits 0..14 are notes and bracket keys; bit 15 (unrecognized) and bits 16..19 are ignored.
- clk  in  1  system clock.
- ar  in  1  reset, asynchronous, active-low.
- key_mask  in  KEY_W  held-key bitmask from keyboard decoder. Asynchronous to clk, since it is clocked by the filtered PS/2 clock.
- panic  in  1  synchronous all-notes-off request, sampled each clk.
- voice_on  out  NUM_VOICES  per-voice gate.
- voice_key  out  NUM_VOICES*5  per-voice key index; voice v occupies bits [5v+4:5v].
- voice_trig  out  NUM_VOICES  one-cycle note-on/retrigger pulse per voice.
- free_cnt  out  4  number of voices with voice_on=0.

## Operation
- **Synchronizer**
  - key_mask passes through two flops: s1, then s2.
  - The effective mask is m = s2 & VALID_MASK.
- **Scan counter** idx (5 bits)
  - Steps 0..KEY_W-1, then wraps to 0, advancing one key per cycle continuously.
  - The per-key register held[KEY_W-1:0] records keys already handled.
- **Evaluation cycle for key idx**, with panic=0:
  - **Press** (m[idx]=1, held[idx]=0):
    - Set held[idx]=1.
    - Target = lowest-index voice with voice_on=0. If none is free, target = voice with the largest age; ties go to the lowest index.
    - Target gets voice_on=1, voice_key=idx, voice_trig=1 for one cycle, and age=0.
    - Every other voice's age increments, saturating at 255.
  - **Release** (m[idx]=0, held[idx]=1):
    - Set held[idx]=0.
    - Any voice with voice_on=1 and voice_key=idx gets voice_on=0. voice_key is retained.
    - If no voice matches (its voice was stolen), nothing else happens.
  - **Otherwise:** no change.
- **Stolen key:** its held bit stays 1, so it does not retrigger. It re-sounds only after a release followed by a new press.
- **Panic** (panic=1 at a clock edge):
  - All voice_on=0 and all voice_trig=0.
  - held = m, so currently held keys do not retrigger.
  - Ages cleared; idx continues advancing.
  - Panic overrides any press or release evaluated in the same cycle.
- **Invariants**
  - At most one voice_trig bit is high per cycle.
  - At most one voice is active per key index.
  - free_cnt = popcount(~voice_on), registered alongside voice_on.
- **Reset (ar=0, asynchronous):**
  - s1, s2, held, idx, and all ages are 0.
  - Outputs: voice_on=0, voice_key=0, voice_trig=0, free_cnt=NUM_VOICES.
  - Reset mid-scan abandons the scan; the first evaluation after release is key 0.

## Timing
- All outputs are registered and update on the clock edge ending the evaluation cycle.
- **Press latency:** a key_mask bit change needs 2 cycles to reach m. The key is evaluated within the next KEY_W cycles. voice_on/voice_trig then update 1 cycle later, so worst case is 2+KEY_W+1 = 23 cycles at default.
- **Release latency:** same bound as press.
- **Pulses shorter than one scan:** a press and release that both complete before key idx is evaluated are never seen. No trigger is issued. This is acceptable because PS/2 events are milliseconds apart.
- **Simultaneous events:** multiple keys changing together are handled in ascending index order, one per cycle, starting from the current idx position.
- **voice_trig:** high exactly one cycle per allocation, including steals. A steal keeps voice_on=1 continuously; only voice_key changes.

## Test plan
- **Reset:** assert ar=0 mid-scan with key_mask=20'h00001 → all outputs 0, free_cnt=4. After release, voice 0 gets key 0 with voice_trig=4'b0001 within 23 cycles.
- **Four presses:** press keys 0, 2, 4, 5 in separate scans → voices 0..3 hold keys 0, 2, 4, 5; free_cnt=0; exactly four trig pulses.
- **Steal:** press key 7 with all voices busy → voice 0 (oldest) gets key 7 with trig; voice_on stays 4'b1111. Releasing key 0 then changes nothing. Releasing key 7 clears voice 0.
- **Free reuse:** release key 2 → voice 1 off, free_cnt=1. Press key 9 → voice 1 gets key 9, not a steal.
- **Ignored keys:** key_mask=20'h08000 or 20'hF0000 → no trig, voice_on unchanged.
- **Panic:** with keys 0 and 3 held, pulse panic → voice_on=0 next cycle and no retrigger afterwards. Release then re-press key 3 → one trig on voice 0.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans the synchronized held-key mask one key per
// cycle and maps presses onto oscillator voices, stealing the oldest when full.
module voice_alloc #(
  parameter int               NUM_VOICES = 4,
  parameter int               KEY_W      = 20,
  parameter logic [KEY_W-1:0] VALID_MASK = 20'h07FFF
) (
  input  logic                    clk,
  input  logic                    ar,
  input  logic [KEY_W-1:0]        key_mask,
  input  logic                    panic,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic [NUM_VOICES*5-1:0] voice_key,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [3:0]              free_cnt
);
  localparam int         VW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [4:0] IDX_LAST = 5'(KEY_W - 1);

  logic [KEY_W-1:0]            s1, s2, m;
  logic [KEY_W-1:0]            held, held_n;
  logic [4:0]                  idx;
  logic [NUM_VOICES-1:0][7:0]  age, age_n;
  logic [NUM_VOICES-1:0]       on_n, trig_n;
  logic [NUM_VOICES*5-1:0]     key_n;
  logic [3:0]                  free_n;
  logic                        press, rel;
  logic                        free_found;
  logic [VW-1:0]               free_idx, old_idx, target;
  logic [7:0]                  old_age;

  assign m     = s2 & VALID_MASK;
  assign press = m[idx] & ~held[idx];
  assign rel   = ~m[idx] & held[idx];

  // Victim choice: lowest free voice, else the oldest (lowest index on ties).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!voice_on[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VW'(v);
      end
    end
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > old_age) begin
        old_age = age[v];
        old_idx = VW'(v);
      end
    end
    target = free_found ? free_idx : old_idx;
  end

  always_comb begin
    on_n   = voice_on;
    key_n  = voice_key;
    trig_n = '0;
    age_n  = age;
    held_n = held;
    if (panic) begin
      on_n   = '0;
      age_n  = '0;
      held_n = m;
    end else if (press) begin
      held_n[idx] = 1'b1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VW'(v) == target) begin
          on_n[v]          = 1'b1;
          key_n[5*v +: 5]  = idx;
          trig_n[v]        = 1'b1;
          age_n[v]         = 8'd0;
        end else if (age[v] != 8'hFF) begin
          age_n[v] = age[v] + 8'd1;
        end
      end
    end else if (rel) begin
      held_n[idx] = 1'b0;
      // A stolen key finds no owner here and the release is simply absorbed.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_on[v] && (voice_key[5*v +: 5] == idx)) on_n[v] = 1'b0;
      end
    end
  end

  always_comb begin
    free_n = '0;
    for (int v = 0; v < NUM_VOICES; v++) free_n = free_n + {3'b000, ~on_n[v]};
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      s1         <= '0;
      s2         <= '0;
      held       <= '0;
      idx        <= '0;
      age        <= '0;
      voice_on   <= '0;
      voice_key  <= '0;
      voice_trig <= '0;
      free_cnt   <= 4'(NUM_VOICES);
    end else begin
      s1         <= key_mask;
      s2         <= s1;
      idx        <= (idx == IDX_LAST) ? 5'd0 : idx + 5'd1;
      held       <= held_n;
      age        <= age_n;
      voice_on   <= on_n;
      voice_key  <= key_n;
      voice_trig <= trig_n;
      free_cnt   <= free_n;
    end
  end

endmodule
